unified_mem_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency unified memory between the pipeline's IF stage (fetch) and MEM stage (load/store).

---
 rtl/unified_mem_arbiter_pkg.sv | 13 +
 rtl/unified_mem_arbiter_lat_timer.sv | 34 +++
 rtl/unified_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter: FSM state encoding and
// latency counter width.
package unified_mem_arbiter_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2
  } arb_state_e;

endpackage

// File: rtl/unified_mem_arbiter_lat_timer.sv
// mem_lat_timer: loadable latency counter. start loads 1, the count then
// advances each cycle and done is high while count equals MEM_LATENCY.
module mem_lat_timer
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic done
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == LAT_W'(MEM_LATENCY));

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = LAT_W'(1);
    end else if (done) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q + LAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency memory port between fetch (IF) and load/store (DM).
// Optional performance counters are enabled with `define MEM_ARB_PERF_EN.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflict_cycles,
  output logic [31:0]       perf_if_wait_cycles
`endif
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              dm_we_q, dm_we_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic              issue, issue_we, if_rdy, dm_rdy, tmr_start, tmr_done;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

  mem_lat_timer #(.MEM_LATENCY(MEM_LATENCY)) u_lat_timer (
    .clk   (clk),
    .rstn  (rstn),
    .start (tmr_start),
    .done  (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    dm_we_d     = dm_we_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    issue       = 1'b0;
    issue_we    = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;
    if_rdy      = 1'b0;
    dm_rdy      = 1'b0;
    tmr_start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!if_req) starve_d = '0;
        if (if_req || dm_req) begin
          issue     = 1'b1;
          tmr_start = 1'b1;
          // DM has priority until a waiting fetch has been passed over STARVE_LIMIT times.
          if (dm_req && !(if_req && starve_q == STARVE_MAX)) begin
            state_d     = ST_BUSY_DM;
            issue_we    = dm_we;
            issue_addr  = dm_addr;
            issue_wdata = dm_wdata;
            dm_we_d     = dm_we;
            if (if_req) starve_d = starve_q + SW'(1);
          end else begin
            state_d    = ST_BUSY_IF;
            issue_addr = if_addr;
            starve_d   = '0;
          end
        end
      end
      ST_BUSY_IF: begin
        if (tmr_done) begin
          if_rdy     = 1'b1;
          if_rdata_d = mem_rdata;
          state_d    = ST_IDLE;
        end
      end
      ST_BUSY_DM: begin
        if (tmr_done) begin
          dm_rdy = 1'b1;
          if (!dm_we_q) dm_rdata_d = mem_rdata;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      dm_we_q    <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      dm_we_q    <= dm_we_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Outputs are forced low while reset is held so an abandoned access leaves no traffic.
  assign mem_req   = rstn & issue;
  assign mem_we    = mem_req & issue_we;
  assign mem_addr  = mem_req ? issue_addr  : '0;
  assign mem_wdata = mem_req ? issue_wdata : '0;
  assign if_ready  = rstn & if_rdy;
  assign dm_ready  = rstn & dm_rdy;
  assign if_rdata  = !rstn ? '0 : (if_ready ? mem_rdata : if_rdata_q);
  assign dm_rdata  = !rstn ? '0 : ((dm_ready && !dm_we_q) ? mem_rdata : dm_rdata_q);

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conf_q, perf_conf_d, perf_wait_q, perf_wait_d;

  always_comb begin
    perf_conf_d = perf_conf_q;
    perf_wait_d = perf_wait_q;
    if (state_q == ST_IDLE && if_req && dm_req) perf_conf_d = perf_conf_q + 32'd1;
    if (if_req && !if_rdy)                      perf_wait_d = perf_wait_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_conf_q <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_conf_q <= perf_conf_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_conflict_cycles = perf_conf_q;
  assign perf_if_wait_cycles  = perf_wait_q;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios followed by
// randomized traffic, all compared against a timestamp-based access model.
module tb_unified_mem_arbiter;

  localparam int LAT = 2;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_req, mem_we;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conflict_cycles, perf_if_wait_cycles;
`endif

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_conflict_cycles(perf_conflict_cycles), .perf_if_wait_cycles(perf_if_wait_cycles)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Memory contents: written words remembered, everything else a fixed hash of the address.
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  bit          rd_pend = 0;
  int          rd_due;
  logic [31:0] rd_data;

  // Reference model: an access issued at cycle c completes at cycle c+LAT.
  bit          m_busy = 0, m_owner_if = 0, m_we = 0;
  int          m_done_at = 0, m_starve = 0;
  logic [31:0] m_word = '0, m_if_rdata = '0, m_dm_rdata = '0;
  logic [31:0] m_conf = '0, m_wait = '0;

  bit          o_if_ready, o_dm_ready, o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;

  task automatic step();
    bit          e_req, e_we, e_ifr, e_dmr, was_idle;
    logic [31:0] e_addr, e_wdata;
    mem_rdata = (rd_pend && cyc == rd_due) ? rd_data : $urandom();
    #1;
`ifdef MEM_ARB_PERF_EN
    check_eq("perf_conflict", perf_conflict_cycles, m_conf);
    check_eq("perf_if_wait", perf_if_wait_cycles, m_wait);
`endif
    e_req = 0; e_we = 0; e_ifr = 0; e_dmr = 0; e_addr = '0; e_wdata = '0;
    was_idle = !m_busy;
    if (!rstn) begin
      m_busy = 0; m_starve = 0; m_if_rdata = '0; m_dm_rdata = '0; m_conf = '0; m_wait = '0;
    end else if (m_busy) begin
      if (cyc == m_done_at) begin
        m_busy = 0;
        if (m_owner_if) begin e_ifr = 1; m_if_rdata = m_word; end
        else begin e_dmr = 1; if (!m_we) m_dm_rdata = m_word; end
      end
    end else begin
      if (!if_req) m_starve = 0;
      if (if_req || dm_req) begin
        e_req = 1; m_busy = 1; m_done_at = cyc + LAT;
        m_owner_if = if_req && (!dm_req || m_starve == LIM);
        if (m_owner_if) begin
          e_addr = if_addr; m_we = 0; m_starve = 0;
        end else begin
          e_addr = dm_addr; e_we = dm_we; e_wdata = dm_wdata; m_we = dm_we;
          if (if_req && m_starve < LIM) m_starve++;
        end
        m_word = e_we ? '0 : rd_word(e_addr);
      end
    end
    if (rstn) begin
      if (was_idle && if_req && dm_req) m_conf++;
      if (if_req && !e_ifr) m_wait++;
    end
    check_eq("mem_req", mem_req, e_req);
    check_eq("mem_we", mem_we, e_we);
    check_eq("mem_addr", mem_addr, e_addr);
    check_eq("mem_wdata", mem_wdata, e_wdata);
    check_eq("if_ready", if_ready, e_ifr);
    check_eq("dm_ready", dm_ready, e_dmr);
    check_eq("if_rdata", if_rdata, m_if_rdata);
    check_eq("dm_rdata", dm_rdata, m_dm_rdata);
    check_eq("ready_excl", if_ready & dm_ready, 0);
    // Memory side reacts to whatever the DUT actually issued.
    if (rd_pend && cyc == rd_due) rd_pend = 0;
    if (!rstn) rd_pend = 0;
    else if (mem_req) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else begin rd_pend = 1; rd_due = cyc + LAT; rd_data = rd_word(mem_addr); end
    end
    o_if_ready = if_ready; o_dm_ready = dm_ready;
    o_mem_req = mem_req; o_mem_we = mem_we; o_mem_addr = mem_addr; o_mem_wdata = mem_wdata;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input bit want_if, input bit want_dm, output int t_if, output int t_dm);
    int n = 0;
    t_if = -1; t_dm = -1;
    while (((want_if && t_if < 0) || (want_dm && t_dm < 0)) && n < 64) begin
      step();
      if (o_if_ready && t_if < 0) t_if = n;
      if (o_dm_ready && t_dm < 0) t_dm = n;
      if (o_if_ready) if_req = 0;
      if (o_dm_ready) dm_req = 0;
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ti, td, cnt, ifs;
    int dm_between [2];
    logic [31:0] prev;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] pc0, pw0;
`endif
    rstn = 0; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    @(negedge clk);
    step(); step();
    rstn = 1;
    step();

    // T1 lone fetch
    if_req = 1; if_addr = 32'h0040_0000;
    run_until(1, 0, ti, td);
    check_eq("t1_if_lat", ti, 2);
    check_eq("t1_if_rdata", if_rdata, rd_word(32'h0040_0000));
    step();

    // T2 simultaneous requests
`ifdef MEM_ARB_PERF_EN
    pc0 = perf_conflict_cycles; pw0 = perf_if_wait_cycles;
`endif
    if_req = 1; if_addr = 32'h0040_0010;
    dm_req = 1; dm_we = 0; dm_addr = 32'h1000_8000; dm_wdata = 32'h1234_5678;
    run_until(1, 1, ti, td);
    check_eq("t2_dm_lat", td, 2);
    check_eq("t2_if_lat", ti, 5);
    step();
`ifdef MEM_ARB_PERF_EN
    check_eq("t6_conflict", perf_conflict_cycles - pc0, 1);
    check_eq("t6_if_wait", perf_if_wait_cycles - pw0, 5);
`endif

    // T3 starvation: both held, count dm grants between fetch completions
    if_req = 1; if_addr = 32'h0040_0020;
    dm_req = 1; dm_we = 0; dm_addr = 32'h1000_8010;
    cnt = 0; ifs = 0;
    for (int i = 0; i < 100 && ifs < 2; i++) begin
      step();
      if (o_dm_ready) cnt++;
      if (o_if_ready) begin dm_between[ifs] = cnt; cnt = 0; ifs++; end
    end
    check_eq("t3_fetches", ifs, 2);
    check_eq("t3_dm_grants_1", dm_between[0], LIM);
    check_eq("t3_dm_grants_2", dm_between[1], LIM);
    if_req = 0; dm_req = 0;
    run_until(1, 1, ti, td);
    if_req = 0; dm_req = 0;
    step(); step();

    // T4 store leaves dm_rdata alone, then read it back
    prev = dm_rdata;
    dm_req = 1; dm_we = 1; dm_addr = 32'h1000_8004; dm_wdata = 32'hDEAD_BEEF;
    step();
    check_eq("t4_mem_we", o_mem_we, 1);
    check_eq("t4_mem_addr", o_mem_addr, 32'h1000_8004);
    check_eq("t4_mem_wdata", o_mem_wdata, 32'hDEAD_BEEF);
    run_until(0, 1, ti, td);
    check_eq("t4_dm_lat", td, 1);
    check_eq("t4_dm_rdata_held", dm_rdata, prev);
    step();
    dm_req = 1; dm_we = 0; dm_addr = 32'h1000_8004;
    run_until(0, 1, ti, td);
    check_eq("t4_readback", dm_rdata, 32'hDEAD_BEEF);
    step();

    // T5 reset one cycle after a fetch issue
    if_req = 1; if_addr = 32'h0040_0030;
    step();
    check_eq("t5_issue", o_mem_req, 1);
    rstn = 0;
    step();
    check_eq("t5_rst_mem_req", o_mem_req, 0);
    check_eq("t5_rst_if_ready", o_if_ready, 0);
    rstn = 1;
    step();
    check_eq("t5_reissue", o_mem_req, 1);
    check_eq("t5_reissue_addr", o_mem_addr, 32'h0040_0030);
    run_until(1, 0, ti, td);
    check_eq("t5_if_lat", ti, 1);
    step();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      rstn = ($urandom_range(0, 299) != 0);
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 32'h0040_0000 + 32'($urandom_range(0, 63)) * 4;
      end
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 32'h1000_8000 + 32'($urandom_range(0, 15)) * 4;
        dm_wdata = $urandom();
      end
      step();
      if (o_if_ready) if_req = 0;
      if (o_dm_ready) dm_req = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
